demux_route: RTL and testbench
==============================

// Module: demux_route
// PURPOSE
//   Registered 1-to-4 stream demultiplexer with valid/ready handshakes.
//   Steers each accepted input word to the output channel chosen by in_sel,
//   and holds it there until that channel's consumer takes it.
//   Sits on the distribution side of the 4-channel select fabric: one
//   producer feeds four independent consumers.
//   A free-running accepted-word counter is provided for debug and scoreboarding.
// PARAMETERS
//   WIDTH    4   data word width in bits
//   CNT_W    8   width of the accepted-word counter
// PORTS
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   in_data    in   WIDTH      input word
//   in_sel     in   2          destination channel for in_data (0..3)
//   in_valid   in   1          input word present
//   in_ready   out  1          block can accept the word for in_sel this cycle
//   out_data   out  4*WIDTH    channel i occupies bits [i*WIDTH +: WIDTH]
//   out_valid  out  4          per-channel word present
//   out_ready  in   4          per-channel consumer accepts
//   xfer_cnt   out  CNT_W      number of accepted input words, wrapping
// BEHAVIOUR
//   Clocking and reset
//   - One clock domain (clk).
//   - Reset is asynchronous and active-low (rst_n).
//   - While rst_n=0: out_valid=4'b0000, out_data=0, xfer_cnt=0.
//   - Reset mid-transfer discards all held words immediately.
//   Storage
//   - One holding register per channel: data_q[i] and valid_q[i].
//   - out_data and out_valid are driven directly from these registers.
//   Ready and accept
//   - in_ready = ~valid_q[in_sel] | out_ready[in_sel].
//   - in_ready is combinational from in_sel and out_ready, with no dependence on in_valid.
//   - Accept occurs when in_valid & in_ready on a rising clk edge.
//   - On accept: data_q[in_sel] <= in_data, valid_q[in_sel] <= 1, xfer_cnt <= xfer_cnt + 1.
//   Latency and throughput
//   - Latency is exactly 1 cycle: a word accepted at edge N is visible on out_* after edge N.
//   - Throughput is 1 word/cycle to a single channel while that consumer holds out_ready=1.
//   Drain
//   - Channel i drains when out_valid[i] & out_ready[i] at a clock edge.
//   - On drain with no simultaneous load to channel i: valid_q[i] <= 0.
//   - data_q[i] retains its last value after drain.
//   Simultaneous events
//   - Drain and load to the same channel in the same edge: the new word replaces the old one and valid_q stays 1.
//   Stability
//   - While out_valid[i]=1 and out_ready[i]=0, out_data channel i is held stable.
//   Backpressure
//   - Backpressure is per destination.
//   - A full, stalled channel blocks only words addressed to it (head-of-line blocking at the input is accepted).
//   - The other channels keep draining independently.
//   Counter
//   - xfer_cnt wraps from 2^CNT_W-1 to 0 with no flag.
//   Input rules
//   - in_sel and in_data are ignored when in_valid=0.
//   - All in_sel codes are legal.
// TESTING
//   1. Reset check: assert rst_n=0 mid-stream.
//      -> out_valid=0000, out_data=0 and xfer_cnt=0 asynchronously, before the next clk edge.
//   2. Routing: in_sel=0..3 with in_data=4'hA,4'hB,4'hC,4'hD, out_ready=1111.
//      -> out_valid[i] pulses one cycle after each accept, channel i carries A/B/C/D, xfer_cnt=4.
//   3. Stall: out_ready[2]=0, send 4'h5 then 4'h6 to channel 2.
//      -> first word held at 5, in_ready=0 for sel=2 while channel 2 is full.
//      -> after out_ready[2]=1, 5 drains and 6 follows on the next cycle.
//   4. Independence: channel 1 stalled and full, send 4'h9 to channel 3.
//      -> in_ready=1, out_valid[3] rises next cycle, channel 1 word is unchanged.
//   5. Streaming: drain and load on the same edge, 16 back-to-back words to channel 0 with out_ready[0]=1.
//      -> out_valid[0] stays high, every word is seen in order, nothing is dropped or duplicated.
//   6. Wrap: 256 accepted words with CNT_W=8.
//      -> xfer_cnt returns to 0.

Source files
------------

// File: rtl/demux_route.sv
// -----------------------------------------------------------------------------
// demux_route
//   Registered 1-to-4 stream demultiplexer with valid/ready handshakes.
//   Each accepted input word is steered into the holding register of the
//   channel selected by in_sel. It stays there until that channel's consumer
//   takes it. Backpressure is per destination, so a stalled channel only
//   blocks words addressed to it. A wrapping counter of accepted input words
//   is provided for debug and scoreboarding.
//
// Ports
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   in_data    in   WIDTH      input word
//   in_sel     in   2          destination channel for in_data (0..3)
//   in_valid   in   1          input word present
//   in_ready   out  1          word for in_sel can be accepted this cycle
//   out_data   out  4*WIDTH    channel i occupies bits [i*WIDTH +: WIDTH]
//   out_valid  out  4          per-channel word present
//   out_ready  in   4          per-channel consumer accepts
//   xfer_cnt   out  CNT_W      number of accepted input words, wrapping
// -----------------------------------------------------------------------------
module demux_route #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [4*WIDTH-1:0]   out_data,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [CNT_W-1:0]     xfer_cnt
);

    localparam int NCH = 4;

    // Per-channel holding registers.
    logic [WIDTH-1:0] r_data [NCH];
    logic [NCH-1:0]   r_valid;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic [NCH-1:0]   w_load;
    logic [NCH-1:0]   w_drain;

    // Ready looks only at the addressed channel: free now, or being emptied
    // by its consumer on this same edge. It never depends on in_valid.
    assign in_ready = ~r_valid[in_sel] | out_ready[in_sel];
    assign w_accept = in_valid & in_ready;
    assign w_drain  = r_valid & out_ready;

    // NOTE: every signal written in a combinational block gets a default
    // first, so no path through the block can leave it unassigned and infer
    // a latch.
    always_comb begin
        w_load = '0;
        if (w_accept) begin
            w_load[in_sel] = 1'b1;
        end
    end

    // NOTE: the data registers are reset as well as the valid bits because
    // out_data must read zero while rst_n is low, and a reset mid-transfer
    // must discard held words at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_data[i] <= '0;
            end
            r_valid <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                // NOTE: non-blocking assignments for all state so every
                // register samples pre-edge values regardless of order.
                if (w_load[i]) begin
                    // A load wins over a simultaneous drain: the new word
                    // replaces the one leaving and the channel stays full.
                    r_data[i]  <= in_data;
                    r_valid[i] <= 1'b1;
                end else if (w_drain[i]) begin
                    // Data is kept after a drain; only the valid bit drops.
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Accepted-word counter, wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < NCH; i++) begin
            out_data[i*WIDTH +: WIDTH] = r_data[i];
        end
    end

    assign out_valid = r_valid;
    assign xfer_cnt  = r_cnt;

endmodule

// File: tb/tb_demux_route.sv
// -----------------------------------------------------------------------------
// tb_demux_route
//   Self-checking bench for demux_route. The reference model counts words
//   pending per channel, remembers the last word delivered to each channel and
//   counts accepted words. Expected outputs are recomputed from those numbers
//   after every clock edge.
// -----------------------------------------------------------------------------
module tb_demux_route;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic                 clk;
    logic                 rst_n;
    logic [WIDTH-1:0]     in_data;
    logic [1:0]           in_sel;
    logic                 in_valid;
    logic                 in_ready;
    logic [4*WIDTH-1:0]   out_data;
    logic [3:0]           out_valid;
    logic [3:0]           out_ready;
    logic [CNT_W-1:0]     xfer_cnt;

    demux_route #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    int               m_pend [4];    // words waiting in each channel
    logic [WIDTH-1:0] m_held [4];    // last word delivered to each channel
    int               m_cnt;         // accepted words, modulo 2^CNT_W
    int               drained_dut [4];

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = 0;
            m_held[i] = '0;
        end
        m_cnt = 0;
    endtask

    // One clock edge as seen by the model.
    task automatic model_edge(input logic v, input logic [1:0] s,
                              input logic [WIDTH-1:0] d, input logic [3:0] r);
        bit acc;
        acc = v && (m_pend[s] == 0 || r[s]);
        for (int i = 0; i < 4; i++) begin
            if (r[i] && m_pend[i] > 0) m_pend[i]--;
        end
        if (acc) begin
            m_pend[s]++;
            m_held[s] = d;
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0]         exp_v;
        logic [4*WIDTH-1:0] exp_d;
        for (int i = 0; i < 4; i++) begin
            exp_v[i] = (m_pend[i] > 0);
            exp_d[i*WIDTH +: WIDTH] = m_held[i];
        end
        check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_v));
        check({tag, ".out_data"},  32'(out_data),  32'(exp_d));
        check({tag, ".xfer_cnt"},  32'(xfer_cnt),  32'(m_cnt));
    endtask

    // Drive one cycle of inputs on the falling edge, check in_ready before
    // the rising edge, then check the registered outputs just after it.
    task automatic step(input string tag, input logic v, input logic [1:0] s,
                        input logic [WIDTH-1:0] d, input logic [3:0] r);
        @(negedge clk);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(m_pend[s] == 0 || r[s]));
        for (int i = 0; i < 4; i++) begin
            if (out_valid[i] && r[i]) drained_dut[i]++;
        end
        @(posedge clk);
        model_edge(v, s, d, r);
        #1;
        check_outputs(tag);
    endtask

    // Assert reset between edges and confirm it acts without a clock edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, ".rst_valid"}, 32'(out_valid), 32'h0);
        check({tag, ".rst_data"},  32'(out_data),  32'h0);
        check({tag, ".rst_cnt"},   32'(xfer_cnt),  32'h0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = '0;
        out_ready = 4'h0;
        model_clear();
        for (int i = 0; i < 4; i++) drained_dut[i] = 0;

        // Power-up reset.
        do_reset("por");

        // Routing: one word per channel, all consumers ready.
        step("route0", 1'b1, 2'd0, 4'hA, 4'hF);
        step("route1", 1'b1, 2'd1, 4'hB, 4'hF);
        step("route2", 1'b1, 2'd2, 4'hC, 4'hF);
        step("route3", 1'b1, 2'd3, 4'hD, 4'hF);
        check("route.cnt4", 32'(xfer_cnt), 32'd4);
        step("route_idle", 1'b0, 2'd0, 4'h0, 4'hF);

        // Stall on channel 2: second word must wait until the first drains.
        step("stall_a", 1'b1, 2'd2, 4'h5, 4'b1011);
        step("stall_b", 1'b1, 2'd2, 4'h6, 4'b1011);
        step("stall_c", 1'b1, 2'd2, 4'h6, 4'b1011);
        check("stall.held5", 32'(out_data[2*WIDTH +: WIDTH]), 32'h5);
        step("stall_d", 1'b1, 2'd2, 4'h6, 4'hF);
        check("stall.now6", 32'(out_data[2*WIDTH +: WIDTH]), 32'h6);
        step("stall_e", 1'b0, 2'd2, 4'h0, 4'hF);

        // Independence: channel 1 full and stalled, channel 3 still accepts.
        step("indep_a", 1'b1, 2'd1, 4'h7, 4'b1101);
        step("indep_b", 1'b1, 2'd3, 4'h9, 4'b1101);
        check("indep.ch1", 32'(out_data[1*WIDTH +: WIDTH]), 32'h7);
        step("indep_c", 1'b1, 2'd1, 4'h3, 4'b1101);
        step("indep_d", 1'b0, 2'd0, 4'h0, 4'hF);

        // Streaming: 16 back-to-back words to channel 0.
        drained_dut[0] = 0;
        for (int k = 0; k < 16; k++) begin
            step("stream", 1'b1, 2'd0, WIDTH'($urandom), 4'b0001);
        end
        step("stream_end", 1'b0, 2'd0, 4'h0, 4'b0001);
        check("stream.drained", 32'(drained_dut[0]), 32'd16);

        // Mid-stream reset with words held in two channels.
        step("mid_a", 1'b1, 2'd0, 4'hE, 4'h0);
        step("mid_b", 1'b1, 2'd3, 4'h1, 4'h0);
        do_reset("mid");
        step("mid_after", 1'b0, 2'd0, 4'h0, 4'hF);

        // Counter wrap: 256 accepted words from reset.
        do_reset("wrap");
        for (int k = 0; k < 256; k++) begin
            step("wrap", 1'b1, 2'($urandom), WIDTH'($urandom), 4'hF);
        end
        check("wrap.zero", 32'(xfer_cnt), 32'd0);
        step("wrap_idle", 1'b0, 2'd0, 4'h0, 4'hF);

        // Random traffic with random per-channel backpressure.
        for (int k = 0; k < 400; k++) begin
            step("rand", ($urandom % 4) != 0, 2'($urandom), WIDTH'($urandom),
                 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
